// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: one single-port frame BRAM shared by VGA scan-out reads (strict priority,
// fixed latency) and FIFO-buffered camera writes. Define ARB_STATS_EN to add grant counters.
module frame_buffer_arbiter #(
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FIFO_AW    = 4,
    parameter int unsigned STARVE_MAX = 1024
) (
    input  logic              i_clk25,
    input  logic              i_rst_n,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
`ifdef ARB_STATS_EN
    output logic [31:0]       o_rd_count,
    output logic [31:0]       o_wr_count,
`endif
    output logic [FIFO_AW:0]  o_fifo_level,
    output logic              o_starve,
    output logic              o_overflow
);

    localparam int unsigned Depth   = 2 ** FIFO_AW;
    localparam int unsigned EntryW  = ADDR_W + DATA_W;
    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
    localparam logic [StarveW-1:0] StarveTop = StarveW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e              r_state;
    state_e              w_next_state;

    logic [EntryW-1:0]   r_fifo [Depth];
    logic [FIFO_AW-1:0]  r_wptr;
    logic [FIFO_AW-1:0]  r_rptr;
    logic [FIFO_AW:0]    r_count;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [EntryW-1:0]   w_head;

    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                r_rd_pend;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;

    logic [StarveW-1:0]  r_starve_cnt;
    logic                w_starve_inc;
    logic                r_starve;
    logic                r_overflow;

    // Count reaches exactly Depth only when full, so its MSB is the full flag.
    assign w_full   = r_count[FIFO_AW];
    assign w_empty  = (r_count == '0);
    assign w_push   = i_wr_valid && !w_full;
    assign w_pop    = (w_next_state == StWrite);
    assign w_head   = r_fifo[r_rptr];

    always_comb begin
        w_next_state = StIdle;
        if (i_rd_en) begin
            w_next_state = StRead;
        end else if (!w_empty) begin
            w_next_state = StWrite;
        end
    end

    // Grant FSM: state and memory port are registered together so mem_* mirror the state.
    always_ff @(posedge i_clk25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            unique case (w_next_state)
                StRead: begin
                    r_mem_en   <= 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= i_rd_addr;
                end
                StWrite: begin
                    r_mem_en    <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= w_head[EntryW-1:DATA_W];
                    r_mem_wdata <= w_head[DATA_W-1:0];
                end
                default: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    // Write FIFO storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clk25) begin
        if (w_push) begin
            r_fifo[r_wptr] <= {i_wr_addr, i_wr_data};
        end
    end

    always_ff @(posedge i_clk25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Memory returns data the cycle after a READ state; capture it one edge later.
    always_ff @(posedge i_clk25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_pend  <= (r_state == StRead);
            r_rd_valid <= r_rd_pend;
            if (r_rd_pend) begin
                r_rd_data <= i_mem_rdata;
            end
        end
    end

    assign w_starve_inc = !w_empty && !w_pop;

    always_ff @(posedge i_clk25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
            r_starve     <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (!w_starve_inc) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != StarveTop) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            if (w_starve_inc && (r_starve_cnt == StarveTop - 1'b1)) begin
                r_starve <= 1'b1;
            end
            if (i_wr_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    always_ff @(posedge i_clk25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_next_state == StRead) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (w_next_state == StWrite) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign o_rd_count = r_rd_count;
    assign o_wr_count = r_wr_count;
`endif

    assign o_mem_en     = r_mem_en;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_rd_data    = r_rd_data;
    assign o_rd_valid   = r_rd_valid;
    assign o_wr_ready   = !w_full;
    assign o_fifo_level = r_count;
    assign o_starve     = r_starve;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: directed bench with a queue-based arbiter model, a behavioural BRAM
// and per-cycle output comparison; STARVE_MAX is reduced to 8.
module tb_frame_buffer_arbiter;

    localparam int AW    = 19;
    localparam int DW    = 12;
    localparam int DEPTH = 16;
    localparam int SMAX  = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [4:0]    fifo_level;
    logic          starve;
    logic          overflow;
`ifdef ARB_STATS_EN
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;
`endif

    always #5 clk = ~clk;

    frame_buffer_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .FIFO_AW   (4),
        .STARVE_MAX(SMAX)
    ) dut (
        .i_clk25     (clk),
        .i_rst_n     (rst_n),
        .i_rd_en     (rd_en),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
`ifdef ARB_STATS_EN
        .o_rd_count  (rd_count),
        .o_wr_count  (wr_count),
`endif
        .o_fifo_level(fifo_level),
        .o_starve    (starve),
        .o_overflow  (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port BRAM with a log of every write it performs.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int  bram [int];
    wr_t wlog [$];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            bram[int'(mem_addr)] = int'(mem_wdata);
            wlog.push_back('{a: mem_addr, d: mem_wdata});
        end else if (mem_en) begin
            mem_rdata <= bram.exists(int'(mem_addr)) ? DW'(bram[int'(mem_addr)]) : '0;
        end
    end

    // Arbiter model: a queue for the FIFO, its own memory image, a 3-deep read delay line.
    int  mm [int];
    wr_t q [$];
    int  e_en, e_we, e_addr, e_wdata, e_starve, e_ovf, scnt;
    int  pv [3];
    int  pd [3];
    bit  model_ok = 1'b0;

    function automatic int mm_rd(input int a);
        return mm.exists(a) ? mm[a] : 0;
    endfunction

    always @(posedge clk) begin : model
        int sz;
        int nv;
        int nd;
        bit wg;
        if (!rst_n) begin
            q.delete();
            e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0;
            e_starve = 0; e_ovf = 0; scnt = 0;
            for (int i = 0; i < 3; i++) begin
                pv[i] = 0;
                pd[i] = 0;
            end
            model_ok = 1'b1;
        end else begin
            sz = q.size();
            wg = 1'b0;
            nv = 0;
            nd = 0;
            if (rd_en) begin
                e_en = 1; e_we = 0; e_addr = int'(rd_addr);
                nv = 1;
                nd = mm_rd(e_addr);
            end else if (sz > 0) begin
                e_en = 1; e_we = 1;
                e_addr  = int'(q[0].a);
                e_wdata = int'(q[0].d);
                mm[e_addr] = e_wdata;
                void'(q.pop_front());
                wg = 1'b1;
            end else begin
                e_en = 0; e_we = 0;
            end
            if (sz > 0 && !wg) begin
                if (scnt < SMAX) scnt++;
            end else begin
                scnt = 0;
            end
            if (scnt >= SMAX) e_starve = 1;
            if (wr_valid) begin
                if (sz < DEPTH) q.push_back('{a: wr_addr, d: wr_data});
                else e_ovf = 1;
            end
            pv[2] = pv[1]; pd[2] = pd[1];
            pv[1] = pv[0]; pd[1] = pd[0];
            pv[0] = nv;    pd[0] = nd;
        end
    end

    always @(negedge clk) begin
        if (rst_n && model_ok) begin
            chk("mem_en", 32'(mem_en), e_en);
            chk("mem_we", 32'(mem_we), e_we);
            chk("mem_addr", 32'(mem_addr), e_addr);
            chk("mem_wdata", 32'(mem_wdata), e_wdata);
            chk("rd_valid", 32'(rd_valid), pv[2]);
            if (pv[2] != 0) chk("rd_data", 32'(rd_data), pd[2]);
            chk("fifo_level", 32'(fifo_level), q.size());
            chk("wr_ready", 32'(wr_ready), (q.size() < DEPTH) ? 1 : 0);
            chk("starve", 32'(starve), e_starve);
            chk("overflow", 32'(overflow), e_ovf);
        end
    end

    int rdq [$];
    int rcyc [$];

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            rdq.push_back(int'(rd_data));
            rcyc.push_back(cyc);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_en = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int c0;
        int bad;
        for (int a = 100; a < 104; a++) begin
            bram[a] = a & 12'hFFF;
            mm[a]   = a & 12'hFFF;
        end
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Write only: five writes drain in order.
        do_reset();
        wlog.delete();
        for (int i = 0; i < 5; i++) begin
            step();
            wr_valid = 1'b1;
            wr_addr  = AW'(i);
            wr_data  = 12'hA50 + DW'(i);
        end
        step();
        wr_valid = 1'b0;
        repeat (6) step();
        chk("wr_only_count", wlog.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < wlog.size()) begin
                chk("wr_only_addr", 32'(wlog[i].a), i);
                chk("wr_only_data", 32'(wlog[i].d), 32'h0A50 + i);
            end
        end
        chk("wr_only_level", 32'(fifo_level), 0);

        // Read priority: 640 reads with 3 writes queued behind them.
        do_reset();
        wlog.delete();
        rdq.delete();
        rcyc.delete();
        step();
        c0 = cyc;
        rd_en = 1'b1; rd_addr = AW'(1000);
        wr_valid = 1'b1; wr_addr = AW'(300); wr_data = 12'h001;
        for (int k = 1; k < 640; k++) begin
            step();
            rd_addr = AW'(1000 + k);
            if (k < 3) begin
                wr_addr = AW'(300 + k);
                wr_data = DW'(k + 1);
            end else begin
                wr_valid = 1'b0;
            end
        end
        step();
        rd_en = 1'b0;
        chk("prio_no_write_during_reads", wlog.size(), 0);
        repeat (8) step();
        chk("prio_writes_after", wlog.size(), 3);
        chk("prio_valid_count", rdq.size(), 640);
        if (rcyc.size() > 0) chk("prio_first_valid", rcyc[0], c0 + 3);
        bad = 0;
        for (int i = 1; i < rcyc.size(); i++) begin
            if (rcyc[i] != rcyc[i-1] + 1) bad++;
        end
        chk("prio_valid_gaps", bad, 0);

        // Overflow: FIFO fills to 16 while reads hold the port; the 17th write is dropped.
        do_reset();
        wlog.delete();
        for (int i = 0; i < 17; i++) begin
            step();
            if (i == 16) begin
                chk("ovf_level_full", 32'(fifo_level), 16);
                chk("ovf_wr_ready", 32'(wr_ready), 0);
                chk("ovf_not_yet", 32'(overflow), 0);
            end
            rd_en = 1'b1; rd_addr = AW'(50);
            wr_valid = 1'b1; wr_addr = AW'(200 + i); wr_data = DW'(i);
        end
        step();
        wr_valid = 1'b0;
        chk("ovf_flag", 32'(overflow), 1);
        rd_en = 1'b0;
        repeat (20) step();
        chk("ovf_written", wlog.size(), 16);
        bad = 0;
        foreach (wlog[i]) if (wlog[i].a == AW'(216)) bad++;
        chk("ovf_17th_absent", bad, 0);

        // Starvation: one queued write blocked by 10 read cycles.
        do_reset();
        step();
        rd_en = 1'b1; rd_addr = AW'(60);
        wr_valid = 1'b1; wr_addr = AW'(400); wr_data = 12'h123;
        step();
        wr_valid = 1'b0;
        for (int b = 1; b <= 9; b++) begin
            step();
            if (b == 7) chk("starve_after7", 32'(starve), 0);
            if (b == 8) chk("starve_after8", 32'(starve), 1);
            if (b == 9) rd_en = 1'b0;
        end
        repeat (3) step();
        chk("starve_sticky", 32'(starve), 1);
        chk("starve_drained", 32'(fifo_level), 0);

        // Read data from preloaded addresses 100..103.
        do_reset();
        rdq.delete();
        for (int i = 0; i < 4; i++) begin
            step();
            rd_en = 1'b1;
            rd_addr = AW'(100 + i);
        end
        step();
        rd_en = 1'b0;
        repeat (5) step();
        chk("rdata_count", rdq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rdq.size()) chk("rdata_value", rdq[i], 32'h064 + i);
        end

        // Reset mid-traffic: reads in flight and FIFO occupied.
        do_reset();
        step();
        rd_en = 1'b1; rd_addr = AW'(101);
        wr_valid = 1'b1; wr_addr = AW'(7); wr_data = 12'h003;
        repeat (3) step();
        chk("midrst_pre_valid", 32'(rd_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_valid", 32'(rd_valid), 0);
        chk("midrst_rd_data", 32'(rd_data), 0);
        chk("midrst_mem_en", 32'(mem_en), 0);
        chk("midrst_mem_we", 32'(mem_we), 0);
        chk("midrst_mem_addr", 32'(mem_addr), 0);
        chk("midrst_level", 32'(fifo_level), 0);
        chk("midrst_wr_ready", 32'(wr_ready), 1);
        idle_inputs();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("postrst_level", 32'(fifo_level), 0);
        chk("postrst_overflow", 32'(overflow), 0);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
